// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter and sequencer giving the CPU or the DMA port the shared memory bus.
// Define ARB_TIMEOUT_EN to bound the wait for mem_ack to TIMEOUT cycles (bus_err pulses on expiry).
module mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  input  logic          dma_rd,
  input  logic          dma_wr,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [1:0]    grant,
  output logic          bus_err,
  output logic [1:0]    dbg_state
);

  // Handshake: rd/wr are levels held until the one-cycle ready pulse of that side;
  // mem_req stays high with stable fields until the one-cycle mem_ack (or a timeout).
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACC_CPU = 2'd1;
  localparam logic [1:0] S_ACC_DMA = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_CPU  = 2'b01;
  localparam logic [1:0] G_DMA  = 2'b10;

  logic [1:0]    r_state;
  logic [1:0]    r_grant;
  logic          r_last_dma;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_dma_rdata;

  logic          w_cpu_req;
  logic          w_dma_req;
  logic          w_pick_cpu;
  logic          w_in_acc;
  logic          w_timeout;
  logic          w_done;
  logic [DW-1:0] w_cap_data;

  assign w_cpu_req  = cpu_rd | cpu_wr;
  assign w_dma_req  = dma_rd | dma_wr;
  // On a tie the side that did not complete the previous access wins.
  assign w_pick_cpu = w_cpu_req & (~w_dma_req | r_last_dma);
  assign w_in_acc   = (r_state == S_ACC_CPU) || (r_state == S_ACC_DMA);
  assign w_done     = w_in_acc && (mem_ack || w_timeout);
  assign w_cap_data = mem_ack ? mem_rdata : '1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_grant     <= G_NONE;
      r_last_dma  <= 1'b1;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_cpu) begin
            r_state <= S_ACC_CPU;
            r_grant <= G_CPU;
            r_we    <= cpu_wr;
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
          end else if (w_dma_req) begin
            r_state <= S_ACC_DMA;
            r_grant <= G_DMA;
            r_we    <= dma_wr;
            r_addr  <= dma_addr;
            r_wdata <= dma_wdata;
          end
        end
        S_ACC_CPU, S_ACC_DMA: begin
          if (w_done) begin
            r_state    <= S_RESP;
            r_last_dma <= (r_state == S_ACC_DMA);
            if (!r_we && (r_state == S_ACC_CPU)) r_cpu_rdata <= w_cap_data;
            if (!r_we && (r_state == S_ACC_DMA)) r_dma_rdata <= w_cap_data;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= G_NONE;
        end
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  logic [CW-1:0] r_to_cnt;
  logic          r_err;

  // Counter is zero on the first ACC cycle; an ack on the expiry cycle still wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (!w_in_acc || w_done) r_to_cnt <= '0;
      else                     r_to_cnt <= r_to_cnt + CW'(1);
      r_err <= w_done && w_timeout;
    end
  end

  assign w_timeout = w_in_acc && !mem_ack && (r_to_cnt == CW'(TIMEOUT - 1));
  assign bus_err   = r_err;
`else
  localparam int unused_timeout = TIMEOUT;

  assign w_timeout = 1'b0;
  assign bus_err   = 1'b0;
`endif

  assign mem_req   = w_in_acc;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign grant     = r_grant;
  assign cpu_rdata = r_cpu_rdata;
  assign dma_rdata = r_dma_rdata;
  assign cpu_ready = (r_state == S_RESP) && (r_grant == G_CPU);
  assign dma_ready = (r_state == S_RESP) && (r_grant == G_DMA);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed vector table, hand-written arbitration/reset/timeout sequences and a
// randomized run against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_rd, cpu_wr, dma_rd, dma_wr;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        cpu_ready, dma_ready;
  logic        mem_req, mem_we, mem_ack, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  grant, dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_rd(dma_rd), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .grant(grant), .bus_err(bus_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d passed %0d", n_checks, n_pass);
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        side_dma;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  delay;
    logic [31:0] rdata;
    logic [1:0]  exp_grant;
    logic        exp_we;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  // scoreboard: {side, rdata expected at the ready pulse}
  logic [32:0] exp_q[$];

  logic [1:0]  exp_order [4];
  bit          rq_pend [2];
  logic [1:0]  rq_rw [2];
  logic [31:0] rq_addr [2];
  logic [31:0] rq_wdata [2];
  int          rq_gap [2];
  logic [31:0] exp_rdata [2];
  bit          prev_req [2];
  bit          in_acc, free_prev, is_rdy, acc_now, prev_mreq;
  int          owner, ack_wait, done, s, model_last;
  int          n_gr, cpu_pulses, dma_pulses, both_cnt, hold_c, hold_d;
  logic [32:0] e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_side(input bit dma, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] d);
    if (dma) begin
      dma_rd = rd; dma_wr = wr; dma_addr = a; dma_wdata = d;
    end else begin
      cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive_side(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_side(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  // Called in the first ACC cycle: hold mem_ack off for delay cycles, then ack; returns in the ready cycle.
  task automatic serve(input string name, input int delay, input logic [31:0] rd_data);
    for (int c = 0; c <= delay; c++) begin
      check({name, "_mem_req"}, mem_req, 1'b1);
      if (c == delay) begin
        mem_ack = 1'b1;
        mem_rdata = rd_data;
      end
      tick();
    end
    mem_ack = 1'b0;
    mem_rdata = $urandom;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_mem_req"}, mem_req, 1'b0);
    check({name, "_mem_we"}, mem_we, 1'b0);
    check({name, "_grant"}, grant, 2'b00);
    check({name, "_cpu_ready"}, cpu_ready, 1'b0);
    check({name, "_dma_ready"}, dma_ready, 1'b0);
    check({name, "_bus_err"}, bus_err, 1'b0);
    check({name, "_mem_addr"}, mem_addr, 32'h0);
    check({name, "_mem_wdata"}, mem_wdata, 32'h0);
    check({name, "_cpu_rdata"}, cpu_rdata, 32'h0);
    check({name, "_dma_rdata"}, dma_rdata, 32'h0);
    check({name, "_state"}, dbg_state, 2'd0);
  endtask

  task automatic apply_rq(input int side);
    drive_side(side[0], rq_pend[side] ? rq_rw[side][0] : 1'b0, rq_pend[side] ? rq_rw[side][1] : 1'b0,
               rq_addr[side], rq_wdata[side]);
  endtask

  initial begin
    vecs[0] = '{side_dma: 1'b0, rd: 1'b1, wr: 1'b0, addr: 32'h0000_0004, wdata: 32'h0, delay: 4'd0,
                rdata: 32'h3C01_0001, exp_grant: 2'b01, exp_we: 1'b0, exp_rdata: 32'h3C01_0001};
    vecs[1] = '{side_dma: 1'b1, rd: 1'b1, wr: 1'b0, addr: 32'h0000_0100, wdata: 32'h0, delay: 4'd5,
                rdata: 32'hDEAD_BEEF, exp_grant: 2'b10, exp_we: 1'b0, exp_rdata: 32'hDEAD_BEEF};
    vecs[2] = '{side_dma: 1'b0, rd: 1'b0, wr: 1'b1, addr: 32'h0000_0008, wdata: 32'h1234_5678, delay: 4'd1,
                rdata: 32'hAAAA_AAAA, exp_grant: 2'b01, exp_we: 1'b1, exp_rdata: 32'h3C01_0001};
    vecs[3] = '{side_dma: 1'b1, rd: 1'b1, wr: 1'b1, addr: 32'h0000_0200, wdata: 32'hCAFE_F00D, delay: 4'd2,
                rdata: 32'hBBBB_BBBB, exp_grant: 2'b10, exp_we: 1'b1, exp_rdata: 32'hDEAD_BEEF};
    vecs[4] = '{side_dma: 1'b0, rd: 1'b1, wr: 1'b0, addr: 32'hFFFF_FFFC, wdata: 32'h0, delay: 4'd3,
                rdata: 32'h0F0F_0F0F, exp_grant: 2'b01, exp_we: 1'b0, exp_rdata: 32'h0F0F_0F0F};
    vecs[5] = '{side_dma: 1'b1, rd: 1'b1, wr: 1'b0, addr: 32'h0000_0000, wdata: 32'h0, delay: 4'd0,
                rdata: 32'h55AA_55AA, exp_grant: 2'b10, exp_we: 1'b0, exp_rdata: 32'h55AA_55AA};
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;

    // reset state
    reset = 1'b0;
    drive_side(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_side(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    repeat (2) tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // directed single-requester vectors
    for (int i = 0; i < NV; i++) begin
      drive_side(vecs[i].side_dma, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      tick();
      for (int c = 0; c <= int'(vecs[i].delay); c++) begin
        check($sformatf("tbl%0d_mem_req", i), mem_req, 1'b1);
        check($sformatf("tbl%0d_grant", i), grant, vecs[i].exp_grant);
        check($sformatf("tbl%0d_mem_we", i), mem_we, vecs[i].exp_we);
        check($sformatf("tbl%0d_mem_addr", i), mem_addr, vecs[i].addr);
        if (vecs[i].exp_we) check($sformatf("tbl%0d_mem_wdata", i), mem_wdata, vecs[i].wdata);
        check($sformatf("tbl%0d_readys_wait", i), {cpu_ready, dma_ready}, 2'b00);
        if (c == int'(vecs[i].delay)) begin
          mem_ack = 1'b1;
          mem_rdata = vecs[i].rdata;
        end
        tick();
      end
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      drive_side(vecs[i].side_dma, 1'b0, 1'b0, vecs[i].addr, vecs[i].wdata);
      check($sformatf("tbl%0d_readys", i), {cpu_ready, dma_ready}, vecs[i].side_dma ? 2'b01 : 2'b10);
      check($sformatf("tbl%0d_resp_mem_req", i), mem_req, 1'b0);
      check($sformatf("tbl%0d_rdata", i), vecs[i].side_dma ? dma_rdata : cpu_rdata, vecs[i].exp_rdata);
      tick();
      check($sformatf("tbl%0d_idle_readys", i), {cpu_ready, dma_ready}, 2'b00);
      check($sformatf("tbl%0d_idle_grant", i), grant, 2'b00);
    end

    // reset asserted while mem_req is high
    drive_side(1'b0, 1'b0, 1'b1, 32'h0000_0044, 32'hA5A5_A5A5);
    tick();
    tick();
    check("rst_pre_mem_req", mem_req, 1'b1);
    check("rst_pre_cpu_rdata", cpu_rdata, 32'h0F0F_0F0F);
    reset = 1'b0;
    #1;
    check_all_zero("rst_mid");
    tick();
    reset = 1'b1;
    tick();
    check("rst_post_grant", grant, 2'b01);
    check("rst_post_mem_addr", mem_addr, 32'h0000_0044);
    check("rst_post_mem_we", mem_we, 1'b1);
    serve("rst_post", 0, 32'h0);
    check("rst_post_cpu_ready", cpu_ready, 1'b1);
    drive_side(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // simultaneous writes straight out of reset: CPU wins the first tie
    do_reset();
    drive_side(1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'h1111_1111);
    drive_side(1'b1, 1'b0, 1'b1, 32'h0000_2000, 32'h2222_2222);
    tick();
    check("tie_first_grant", grant, 2'b01);
    check("tie_first_addr", mem_addr, 32'h0000_1000);
    check("tie_first_we", mem_we, 1'b1);
    check("tie_first_wdata", mem_wdata, 32'h1111_1111);
    serve("tie_cpu", 0, 32'h0);
    check("tie_cpu_readys", {cpu_ready, dma_ready}, 2'b10);
    drive_side(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("tie_idle_readys", {cpu_ready, dma_ready}, 2'b00);
    check("tie_idle_grant", grant, 2'b00);
    tick();
    check("tie_second_grant", grant, 2'b10);
    check("tie_second_addr", mem_addr, 32'h0000_2000);
    check("tie_second_wdata", mem_wdata, 32'h2222_2222);
    serve("tie_dma", 2, 32'h0);
    check("tie_dma_readys", {cpu_ready, dma_ready}, 2'b01);
    drive_side(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("tie_end_readys", {cpu_ready, dma_ready}, 2'b00);

    // continuous contention: each side re-requests as soon as it legally can
    drive_side(1'b0, 1'b1, 1'b0, 32'h0000_5000, 32'h0);
    drive_side(1'b1, 1'b1, 1'b0, 32'h0000_6000, 32'h0);
    n_gr = 0; cpu_pulses = 0; dma_pulses = 0; both_cnt = 0; hold_c = 0; hold_d = 0; prev_mreq = 1'b0;
    for (int cyc = 0; cyc < 40 && (cpu_pulses + dma_pulses) < 4; cyc++) begin
      tick();
      if (hold_c > 0) begin hold_c--; if (hold_c == 0) cpu_rd = 1'b1; end
      if (hold_d > 0) begin hold_d--; if (hold_d == 0) dma_rd = 1'b1; end
      if (mem_req && !prev_mreq) begin
        if (n_gr < 4) check($sformatf("rr_grant%0d", n_gr), grant, exp_order[n_gr]);
        n_gr++;
      end
      prev_mreq = mem_req;
      mem_ack = mem_req;
      if (cpu_ready && dma_ready) both_cnt++;
      if (cpu_ready) begin cpu_pulses++; cpu_rd = 1'b0; hold_c = 2; end
      if (dma_ready) begin dma_pulses++; dma_rd = 1'b0; hold_d = 2; end
    end
    mem_ack = 1'b0;
    cpu_rd = 1'b0;
    dma_rd = 1'b0;
    tick();
    tick();
    check("rr_grants", n_gr, 4);
    check("rr_cpu_pulses", cpu_pulses, 2);
    check("rr_dma_pulses", dma_pulses, 2);
    check("rr_overlap", both_cnt, 0);
    check("rr_quiet", mem_req, 1'b0);

    // CPU served alone, then a fresh tie must go to the DMA
    drive_side(1'b0, 1'b0, 1'b1, 32'h0000_7000, 32'h7777_7777);
    tick();
    serve("lg_cpu", 1, 32'h0);
    check("lg_cpu_ready", cpu_ready, 1'b1);
    drive_side(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    drive_side(1'b0, 1'b1, 1'b0, 32'h0000_7100, 32'h0);
    drive_side(1'b1, 1'b1, 1'b0, 32'h0000_7200, 32'h0);
    tick();
    check("lg_tie_grant", grant, 2'b10);
    check("lg_tie_addr", mem_addr, 32'h0000_7200);
    serve("lg_dma", 0, 32'h7272_7272);
    check("lg_dma_readys", {cpu_ready, dma_ready}, 2'b01);
    check("lg_dma_rdata", dma_rdata, 32'h7272_7272);
    drive_side(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    check("lg_next_grant", grant, 2'b01);
    check("lg_next_addr", mem_addr, 32'h0000_7100);
    serve("lg_cpu2", 0, 32'h7171_7171);
    check("lg_cpu2_rdata", cpu_rdata, 32'h7171_7171);
    drive_side(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // randomized run against the transaction-level model
    do_reset();
    model_last = 1;
    in_acc = 1'b0;
    free_prev = 1'b1;
    done = 0;
    owner = 0;
    ack_wait = 0;
    exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      rq_pend[k] = 1'b0; rq_gap[k] = 0; rq_rw[k] = 2'b00; rq_addr[k] = 32'h0; rq_wdata[k] = 32'h0;
      exp_rdata[k] = 32'h0; prev_req[k] = 1'b0;
    end
    for (int cyc = 0; cyc < 3000 && done < 60; cyc++) begin
      tick();
      is_rdy = (exp_q.size() != 0);
      if (is_rdy) begin
        e = exp_q.pop_front();
        s = int'(e[32]);
        check("rnd_cpu_ready", cpu_ready, s == 0);
        check("rnd_dma_ready", dma_ready, s == 1);
        check("rnd_resp_grant", grant, (s == 1) ? 2'b10 : 2'b01);
        exp_rdata[s] = e[31:0];
        model_last = s;
        rq_pend[s] = 1'b0;
        rq_gap[s] = $urandom_range(2, 5);
        done++;
      end else begin
        check("rnd_no_ready", {cpu_ready, dma_ready}, 2'b00);
      end
      check("rnd_cpu_rdata", cpu_rdata, exp_rdata[0]);
      check("rnd_dma_rdata", dma_rdata, exp_rdata[1]);
      check("rnd_bus_err", bus_err, 1'b0);
      if (!in_acc && !is_rdy && free_prev && (prev_req[0] || prev_req[1])) begin
        owner = (prev_req[0] && prev_req[1]) ? (1 - model_last) : (prev_req[0] ? 0 : 1);
        in_acc = 1'b1;
        ack_wait = $urandom_range(0, 4);
      end
      acc_now = in_acc;
      check("rnd_mem_req", mem_req, acc_now);
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (acc_now) begin
        check("rnd_grant", grant, (owner == 1) ? 2'b10 : 2'b01);
        check("rnd_mem_addr", mem_addr, rq_addr[owner]);
        check("rnd_mem_we", mem_we, rq_rw[owner][1]);
        if (rq_rw[owner][1]) check("rnd_mem_wdata", mem_wdata, rq_wdata[owner]);
        if (ack_wait == 0) begin
          mem_ack = 1'b1;
          in_acc = 1'b0;
          exp_q.push_back({owner[0], rq_rw[owner][1] ? exp_rdata[owner] : mem_rdata});
        end else begin
          ack_wait--;
        end
      end else if (!is_rdy) begin
        check("rnd_idle_grant", grant, 2'b00);
      end
      free_prev = !acc_now && !is_rdy;
      for (int k = 0; k < 2; k++) begin
        if (!rq_pend[k]) begin
          if (rq_gap[k] > 0) rq_gap[k]--;
          else if ($urandom_range(0, 1) == 1) begin
            rq_pend[k] = 1'b1;
            rq_rw[k] = 2'($urandom_range(1, 3));
            rq_addr[k] = $urandom;
            rq_wdata[k] = $urandom;
          end
        end
        apply_rq(k);
        prev_req[k] = rq_pend[k];
      end
    end
    check("rnd_completed", done, 60);
    mem_ack = 1'b0;

    // dead slave: timeout build reports bus_err, default build keeps waiting
    do_reset();
    drive_side(1'b0, 1'b1, 1'b0, 32'h0000_3000, 32'h0);
    tick();
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c <= 15; c++) begin
      check($sformatf("to_wait%0d_mem_req", c), mem_req, 1'b1);
      check($sformatf("to_wait%0d_ready", c), cpu_ready, 1'b0);
      tick();
    end
    check("to_cpu_ready", cpu_ready, 1'b1);
    check("to_bus_err", bus_err, 1'b1);
    check("to_cpu_rdata", cpu_rdata, 32'hFFFF_FFFF);
    check("to_mem_req", mem_req, 1'b0);
    drive_side(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("to_idle_bus_err", bus_err, 1'b0);
    drive_side(1'b0, 1'b1, 1'b0, 32'h0000_3004, 32'h0);
    tick();
    repeat (14) tick();
    check("to_edge_mem_req", mem_req, 1'b1);
    mem_ack = 1'b1;
    mem_rdata = 32'h600D_F00D;
    tick();
    mem_ack = 1'b0;
    check("to_edge_ready", cpu_ready, 1'b1);
    check("to_edge_bus_err", bus_err, 1'b0);
    check("to_edge_rdata", cpu_rdata, 32'h600D_F00D);
`else
    for (int c = 1; c <= 30; c++) begin
      check($sformatf("nto_wait%0d_mem_req", c), mem_req, 1'b1);
      check($sformatf("nto_wait%0d_ready", c), cpu_ready, 1'b0);
      check($sformatf("nto_wait%0d_bus_err", c), bus_err, 1'b0);
      tick();
    end
    check("nto_addr", mem_addr, 32'h0000_3000);
    mem_ack = 1'b1;
    mem_rdata = 32'h600D_F00D;
    tick();
    mem_ack = 1'b0;
    check("nto_ready", cpu_ready, 1'b1);
    check("nto_bus_err", bus_err, 1'b0);
    check("nto_rdata", cpu_rdata, 32'h600D_F00D);
`endif
    drive_side(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("final_idle", {mem_req, cpu_ready, dma_ready}, 3'b000);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
